// File: rtl/iob_eth_mii_rx.sv
// iob_eth_mii_rx: MII receive framer.
// Strips the preamble/SFD, packs nibbles into bytes (low nibble first), writes each byte to a
// receive buffer and checks the CRC-32 FCS. The completed frame is held until software acks it.
//
// Parameters
//   BUFFER_W   byte-address width of the receive buffer; max frame stored is 2^BUFFER_W-1 bytes
// Ports
//   clk        RX_CLK from the PHY, rising edge
//   rst        asynchronous active-high reset
//   rx_dv      MII receive data valid
//   rx_data    MII receive nibble
//   rcv_ack    software pulse releasing the held frame
//   wr_en      buffer write strobe, one cycle per byte
//   wr_addr    buffer byte address
//   wr_data    byte to write
//   rx_ready   a complete frame is held
//   rx_nbytes  byte count of the held frame, FCS included
//   crc_err    FCS check failed (or frame too short / overflowed)
//   overflow   held frame exceeded buffer capacity
module iob_eth_mii_rx #(
  parameter int unsigned BUFFER_W = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_dv,
  input  logic [3:0]          rx_data,
  input  logic                rcv_ack,
  output logic                wr_en,
  output logic [BUFFER_W-1:0] wr_addr,
  output logic [7:0]          wr_data,
  output logic                rx_ready,
  output logic [BUFFER_W-1:0] rx_nbytes,
  output logic                crc_err,
  output logic                overflow
);

  localparam logic [BUFFER_W-1:0] MaxCount   = '1;
  localparam logic [31:0]         CrcInit    = 32'hFFFF_FFFF;
  localparam logic [31:0]         CrcPoly    = 32'hEDB8_8320;
  // Register value after running the CRC over data plus a correct FCS.
  localparam logic [31:0]         CrcResidue = 32'hDEBB_20E3;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StData,
    StDone,
    StSkip
  } state_t;

  state_t              state_q;
  logic [3:0]          lo_nib_q;
  logic                hi_phase_q;  // next DATA nibble is the high half of a byte
  logic [BUFFER_W-1:0] count_q;
  logic [31:0]         crc_q;
  logic                ovf_q;

  logic [7:0]          byte_w;
  logic [31:0]         crc_next;

  // Reflected CRC-32, one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    byte_w   = {rx_data, lo_nib_q};
    crc_next = crc_byte(crc_q, byte_w);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      lo_nib_q   <= 4'h0;
      hi_phase_q <= 1'b0;
      count_q    <= '0;
      crc_q      <= CrcInit;
      ovf_q      <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'h00;
      rx_ready   <= 1'b0;
      rx_nbytes  <= '0;
      crc_err    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx_dv) begin
            state_q <= (rx_data == 4'h5) ? StPreamble : StSkip;
          end
        end

        StPreamble: begin
          if (!rx_dv) begin
            state_q <= StIdle;
          end else if (rx_data == 4'hD) begin
            state_q    <= StData;
            count_q    <= '0;
            crc_q      <= CrcInit;
            ovf_q      <= 1'b0;
            hi_phase_q <= 1'b0;
          end else if (rx_data != 4'h5) begin
            state_q <= StSkip;
          end
        end

        StData: begin
          if (!rx_dv) begin
            // A pending low nibble is simply dropped: count and CRC only cover whole bytes.
            state_q   <= StDone;
            rx_ready  <= 1'b1;
            rx_nbytes <= count_q;
            overflow  <= ovf_q;
            crc_err   <= ovf_q || (crc_q != CrcResidue) || (count_q < BUFFER_W'(4));
          end else if (!hi_phase_q) begin
            lo_nib_q   <= rx_data;
            hi_phase_q <= 1'b1;
          end else begin
            hi_phase_q <= 1'b0;
            if (count_q == MaxCount) begin
              ovf_q <= 1'b1;
            end else begin
              wr_en   <= 1'b1;
              wr_addr <= count_q;
              wr_data <= byte_w;
              count_q <= count_q + BUFFER_W'(1);
              crc_q   <= crc_next;
            end
          end
        end

        StDone: begin
          // Anything arriving while the frame is held is ignored; if a frame is in flight at
          // ack time it is dropped via StSkip.
          if (rcv_ack) begin
            rx_ready <= 1'b0;
            crc_err  <= 1'b0;
            overflow <= 1'b0;
            state_q  <= rx_dv ? StSkip : StIdle;
          end
        end

        StSkip: begin
          if (!rx_dv) begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_eth_mii_rx.sv
// Directed self-checking bench for iob_eth_mii_rx: a default instance and a BUFFER_W=6 instance
// share all inputs.
module tb_iob_eth_mii_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_dv;
  logic [3:0]  rx_data;
  logic        rcv_ack;

  logic        wr_en, rx_ready, crc_err, overflow;
  logic [10:0] wr_addr, rx_nbytes;
  logic [7:0]  wr_data;

  logic        wr_en_s, rx_ready_s, crc_err_s, overflow_s;
  logic [5:0]  wr_addr_s, rx_nbytes_s;
  logic [7:0]  wr_data_s;

  int tests = 0;
  int fails = 0;

  logic [7:0]  frame [0:127];
  logic [7:0]  log_data [0:1023];
  int          log_addr [0:1023];
  int          w_total = 0;
  int          ws_total = 0;
  int          ws_last = 0;

  iob_eth_mii_rx dut (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_data(rx_data), .rcv_ack(rcv_ack),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rx_ready(rx_ready),
    .rx_nbytes(rx_nbytes), .crc_err(crc_err), .overflow(overflow)
  );

  iob_eth_mii_rx #(.BUFFER_W(6)) dut_s (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_data(rx_data), .rcv_ack(rcv_ack),
    .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s), .rx_ready(rx_ready_s),
    .rx_nbytes(rx_nbytes_s), .crc_err(crc_err_s), .overflow(overflow_s)
  );

  always #5 clk = ~clk;

  // Write logger, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en && w_total < 1024) begin
      log_data[w_total] <= wr_data;
      log_addr[w_total] <= int'(wr_addr);
      w_total           <= w_total + 1;
    end
    if (wr_en_s) begin
      ws_total <= ws_total + 1;
      ws_last  <= int'(wr_addr_s);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] calc_crc(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frame[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  // n bytes total: n-4 payload bytes (i+off) followed by the little-endian FCS.
  task automatic build(input int n, input int off);
    logic [31:0] fcs;
    for (int i = 0; i < n - 4; i++) frame[i] = 8'(i + off);
    fcs = ~calc_crc(n - 4);
    frame[n-4] = fcs[7:0];
    frame[n-3] = fcs[15:8];
    frame[n-2] = fcs[23:16];
    frame[n-1] = fcs[31:24];
  endtask

  task automatic send_nib(input logic [3:0] n);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_data = n;
    rcv_ack = 1'b0;
  endtask

  task automatic send_preamble();
    for (int i = 0; i < 7; i++) begin
      send_nib(4'h5);
      send_nib(4'h5);
    end
    send_nib(4'h5);
    send_nib(4'hD);
  endtask

  task automatic end_frame();
    @(negedge clk);
    rx_dv   = 1'b0;
    rx_data = 4'h0;
    rcv_ack = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ack_at: data-nibble index at which rcv_ack is raised for one cycle (-1 = never).
  task automatic send_frame(input int n, input bit extra, input int ack_at);
    int k;
    k = 0;
    send_preamble();
    for (int i = 0; i < n; i++) begin
      send_nib(frame[i][3:0]);
      if (k == ack_at) rcv_ack = 1'b1;
      k++;
      send_nib(frame[i][7:4]);
      if (k == ack_at) rcv_ack = 1'b1;
      k++;
    end
    if (extra) send_nib(4'h3);
    end_frame();
  endtask

  task automatic ack();
    @(negedge clk);
    rcv_ack = 1'b1;
    @(negedge clk);
    rcv_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_writes(input string tag, input int base, input int n);
    check({tag, "_nwrites"}, 32'(w_total - base), 32'(n));
    for (int i = 0; i < n && base + i < 1024; i++) begin
      check({tag, "_addr"}, 32'(log_addr[base+i]), 32'(i));
      check({tag, "_data"}, {24'h0, log_data[base+i]}, {24'h0, frame[i]});
    end
  endtask

  initial begin
    int base;
    int sbase;
    rst     = 1'b1;
    rx_dv   = 1'b0;
    rx_data = 4'h0;
    rcv_ack = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_wr_en", {31'h0, wr_en}, 32'h0);
    check("rst_wr_addr", {21'h0, wr_addr}, 32'h0);
    check("rst_wr_data", {24'h0, wr_data}, 32'h0);
    check("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
    check("rst_rx_nbytes", {21'h0, rx_nbytes}, 32'h0);
    check("rst_crc_err", {31'h0, crc_err}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    rst = 1'b0;
    ack();  // ack outside DONE: must be harmless

    // Good 64-byte frame
    build(64, 0);
    base = w_total;
    send_frame(64, 1'b0, -1);
    check_writes("good", base, 64);
    check("good_ready", {31'h0, rx_ready}, 32'h1);
    check("good_nbytes", {21'h0, rx_nbytes}, 32'd64);
    check("good_crc_err", {31'h0, crc_err}, 32'h0);
    check("good_overflow", {31'h0, overflow}, 32'h0);
    // DONE holds while rx_data toggles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_data = 4'(i * 5 + 3);
    end
    @(negedge clk);
    check("hold_ready", {31'h0, rx_ready}, 32'h1);
    check("hold_nbytes", {21'h0, rx_nbytes}, 32'd64);
    ack();
    check("ack_ready", {31'h0, rx_ready}, 32'h0);

    // Same frame, one payload bit flipped
    build(64, 0);
    frame[5] = frame[5] ^ 8'h10;
    send_frame(64, 1'b0, -1);
    check("flip_nbytes", {21'h0, rx_nbytes}, 32'd64);
    check("flip_crc_err", {31'h0, crc_err}, 32'h1);
    check("flip_ready", {31'h0, rx_ready}, 32'h1);
    ack();
    check("flip_ack_crc_err", {31'h0, crc_err}, 32'h0);

    // 80-byte frame: overflows the BUFFER_W=6 instance
    build(80, 32);
    base  = w_total;
    sbase = ws_total;
    send_frame(80, 1'b0, -1);
    check("ovf_s_nwrites", 32'(ws_total - sbase), 32'd63);
    check("ovf_s_last_addr", 32'(ws_last), 32'd62);
    check("ovf_s_nbytes", {26'h0, rx_nbytes_s}, 32'd63);
    check("ovf_s_overflow", {31'h0, overflow_s}, 32'h1);
    check("ovf_s_crc_err", {31'h0, crc_err_s}, 32'h1);
    check("ovf_big_nwrites", 32'(w_total - base), 32'd80);
    check("ovf_big_nbytes", {21'h0, rx_nbytes}, 32'd80);
    check("ovf_big_crc_err", {31'h0, crc_err}, 32'h0);
    ack();
    check("ovf_ack_overflow", {31'h0, overflow_s}, 32'h0);

    // Frame arriving during DONE, acked mid-frame, is dropped; the next one is received
    build(64, 3);
    send_frame(64, 1'b0, -1);
    build(64, 7);
    base = w_total;
    send_frame(64, 1'b0, 20);
    check("drop_nwrites", 32'(w_total - base), 32'd0);
    check("drop_ready", {31'h0, rx_ready}, 32'h0);
    build(64, 40);
    base = w_total;
    send_frame(64, 1'b0, -1);
    check_writes("third", base, 64);
    check("third_nbytes", {21'h0, rx_nbytes}, 32'd64);
    check("third_crc_err", {31'h0, crc_err}, 32'h0);
    ack();

    // Reset at byte 10
    build(64, 0);
    base = w_total;
    send_preamble();
    for (int i = 0; i < 10; i++) begin
      send_nib(frame[i][3:0]);
      send_nib(frame[i][7:4]);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_wr_en", {31'h0, wr_en}, 32'h0);
    check("mid_rst_wr_addr", {21'h0, wr_addr}, 32'h0);
    check("mid_rst_wr_data", {24'h0, wr_data}, 32'h0);
    check("mid_rst_nbytes", {21'h0, rx_nbytes}, 32'h0);
    check("mid_rst_ready", {31'h0, rx_ready}, 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 10; i < 64; i++) begin
      send_nib(frame[i][3:0]);
      send_nib(frame[i][7:4]);
    end
    end_frame();
    check("rst_frame_nwrites", 32'(w_total - base), 32'd10);
    check("rst_frame_ready", {31'h0, rx_ready}, 32'h0);
    build(64, 9);
    base = w_total;
    send_frame(64, 1'b0, -1);
    check_writes("post_rst", base, 64);
    check("post_rst_nbytes", {21'h0, rx_nbytes}, 32'd64);
    check("post_rst_crc_err", {31'h0, crc_err}, 32'h0);
    ack();

    // Dangling odd nibble discarded
    build(64, 17);
    base = w_total;
    send_frame(64, 1'b1, -1);
    check("odd_nwrites", 32'(w_total - base), 32'd64);
    check("odd_nbytes", {21'h0, rx_nbytes}, 32'd64);
    check("odd_crc_err", {31'h0, crc_err}, 32'h0);
    ack();

    // Runt frame (count < 4)
    frame[0] = 8'h01;
    frame[1] = 8'h02;
    frame[2] = 8'h03;
    send_frame(3, 1'b0, -1);
    check("runt_nbytes", {21'h0, rx_nbytes}, 32'd3);
    check("runt_crc_err", {31'h0, crc_err}, 32'h1);
    check("runt_overflow", {31'h0, overflow}, 32'h0);
    ack();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iob_eth_mii_rx.md
IOB_ETH_MII_RX -- requirements
Module: iob_eth_mii_rx

Interface
REQ-001 Parameter: BUFFER_W, default 11, byte-address width of the receive buffer; maximum storable frame is 2^BUFFER_W-1 bytes.
REQ-002 clk  input  1  receive clock, RX_CLK from the PHY; all logic on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 rx_dv  input  1  MII receive data valid.
REQ-005 rx_data  input  4  MII receive nibble; low nibble of each byte arrives first.
REQ-006 rcv_ack  input  1  software pulse releasing the completed frame.
REQ-007 wr_en  output  1  buffer write strobe, one cycle per byte.
REQ-008 wr_addr  output  BUFFER_W  buffer byte address.
REQ-009 wr_data  output  8  byte to write.
REQ-010 rx_ready  output  1  a complete frame is held in the buffer.
REQ-011 rx_nbytes  output  BUFFER_W  byte count of the held frame, FCS included.
REQ-012 crc_err  output  1  FCS check failed for the held frame.
REQ-013 overflow  output  1  held frame exceeded buffer capacity.

Function
REQ-014 The state machine SHALL have the states IDLE, PREAMBLE, DATA, DONE and SKIP; all outputs SHALL be registered.
REQ-015 In IDLE: rx_dv=1 with nibble 0x5 -> PREAMBLE; rx_dv=1 with any other nibble -> SKIP; otherwise stay in IDLE.
REQ-016 In PREAMBLE: nibble 0x5 -> stay; nibble 0xD (SFD high nibble) -> DATA with byte counter and CRC cleared; other nibble -> SKIP; rx_dv=0 -> IDLE.
REQ-017 In DATA: nibbles SHALL be paired low-then-high into bytes; a completed byte SHALL appear on wr_data/wr_addr with wr_en=1 in the cycle after its high nibble is sampled; wr_addr SHALL start at 0 and increment by 1 per byte.
REQ-018 CRC SHALL be CRC-32 IEEE 802.3, reflected (poly 0xEDB88320), init 0xFFFFFFFF, computed over every byte after the SFD including the 4 FCS bytes; the frame is good if and only if the final register equals 0xDEBB20E3.
REQ-019 In DATA with rx_dv=0 -> DONE: rx_ready=1, rx_nbytes=byte count, crc_err=(residue mismatch or count<4), all set in the same cycle; a dangling odd nibble SHALL be discarded.
REQ-020 Once the byte count reaches 2^BUFFER_W-1: further bytes SHALL NOT be written; rx_nbytes SHALL saturate; overflow=1 at DONE; crc_err=1.
REQ-021 In DONE: rx_ready, rx_nbytes, crc_err and overflow SHALL hold; rx_data SHALL be ignored.
REQ-022 rcv_ack in DONE SHALL clear rx_ready, crc_err and overflow the next cycle; next state is SKIP if rx_dv=1 in that cycle, else IDLE.
REQ-023 In SKIP: no writes; stay until rx_dv=0, then IDLE; a frame whose preamble begins during DONE is dropped in its entirety.
REQ-024 rcv_ack outside DONE SHALL have no effect.

Reset
REQ-025 On rst: state=IDLE; wr_en=0, wr_addr=0, wr_data=0, rx_ready=0, rx_nbytes=0, crc_err=0, overflow=0; CRC register=0xFFFFFFFF.
REQ-026 rst asserted mid-frame SHALL abort the frame immediately with no further writes; after release, the remainder of that frame SHALL be handled per REQ-015 (non-0x5 nibble -> SKIP).

Verification
REQ-027 7x 0x55 + 0xD5, then a 64-byte frame with a valid FCS -> 64 wr_en pulses, wr_addr 0..63, bytes matching the input; rx_ready=1, rx_nbytes=64, crc_err=0, overflow=0.
REQ-028 Same frame with one payload bit flipped -> rx_nbytes=64, crc_err=1.
REQ-029 BUFFER_W=6, 80-byte frame -> exactly 63 writes, rx_nbytes=63, overflow=1, crc_err=1.
REQ-030 A second frame arrives while in DONE; rcv_ack is pulsed mid-frame -> zero writes for the second frame; state IDLE after its rx_dv falls; a third frame is received normally.
REQ-031 rst pulsed at byte 10 of a frame -> outputs return to reset values, no writes thereafter; the next clean frame is received correctly.
REQ-032 Frame ending on an odd nibble (129 nibbles after the SFD, valid FCS over the first 64 bytes) -> rx_nbytes=64, crc_err=0.
